// File: rtl/fpu_issue_sequencer.sv
// Issue sequencer for the single non-pipelined FPU: times the in-flight op from funct7,
// raises ID stalls on hazards against the pending result and strobes writeback on completion.
module fpu_issue_sequencer #(
  parameter int unsigned LAT_ADD  = 3,
  parameter int unsigned LAT_MUL  = 4,
  parameter int unsigned LAT_DIV  = 12,
  parameter int unsigned LAT_SQRT = 16,
  parameter int unsigned LAT_MISC = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       id_valid,
  input  logic [6:0] opcode_id,
  input  logic [6:0] funct7_id,
  input  logic [4:0] rd_id,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       rs1_fpu_id,
  input  logic       rs2_fpu_id,
  input  logic       flush,
  output logic       stall_id,
  output logic       fpu_start,
  output logic       fpu_busy,
  output logic       fpu_done,
  output logic [4:0] wb_rd,
  output logic       wb_to_int
);

  localparam logic [6:0] OP_FP  = 7'b1010011;
  localparam logic [6:0] OP_FLW = 7'b0000111;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t     state_r, state_nxt_s;
  logic [4:0] count_r, count_nxt_s;
  logic [4:0] pend_rd_r, pend_rd_nxt_s;
  logic       pend_int_r, pend_int_nxt_s;
  logic       hazard_s, issue_s, done_nxt_s;
  logic       fpu_start_r, fpu_busy_r, fpu_done_r, wb_to_int_r;
  logic [4:0] wb_rd_r;

  // Cycle count minus one, so the done cycle is the one where count reaches zero.
  function automatic logic [4:0] lat_m1(input logic [6:0] f7);
    case (f7)
      7'b0000000, 7'b0000100: lat_m1 = 5'(LAT_ADD - 1);
      7'b0001000:             lat_m1 = 5'(LAT_MUL - 1);
      7'b0001100:             lat_m1 = 5'(LAT_DIV - 1);
      7'b0101100:             lat_m1 = 5'(LAT_SQRT - 1);
      default:                lat_m1 = 5'(LAT_MISC - 1);
    endcase
  endfunction

  function automatic logic dest_is_int(input logic [6:0] f7);
    dest_is_int = (f7 == 7'b1010000) || (f7 == 7'b1100000);
  endfunction

  function automatic logic op_writes_int(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: op_writes_int = 1'b1;
      default:                            op_writes_int = 1'b0;
    endcase
  endfunction

  // Hazard detection against the pending result; kept independent of flush.
  always_comb begin
    hazard_s = 1'b0;
    if (!id_valid) begin
      hazard_s = 1'b0;
    end else if (opcode_id == OP_FP || opcode_id == OP_FLW) begin
      hazard_s = 1'b1;
    end else if (!pend_int_r) begin
      hazard_s = (rs1_fpu_id && rs1_id == pend_rd_r) || (rs2_fpu_id && rs2_id == pend_rd_r);
    end else begin
      hazard_s = op_writes_int(opcode_id) ||
                 ((pend_rd_r != 5'd0) &&
                  ((!rs1_fpu_id && rs1_id == pend_rd_r) || (!rs2_fpu_id && rs2_id == pend_rd_r)));
    end
    stall_id = (state_r == RUN) && hazard_s;
  end

  // Next-state logic for the issue/run sequence.
  always_comb begin
    state_nxt_s    = state_r;
    count_nxt_s    = count_r;
    pend_rd_nxt_s  = pend_rd_r;
    pend_int_nxt_s = pend_int_r;
    issue_s        = id_valid && (opcode_id == OP_FP) && !stall_id && !flush && (state_r == IDLE);
    case (state_r)
      IDLE: begin
        if (issue_s) begin
          state_nxt_s    = RUN;
          count_nxt_s    = lat_m1(funct7_id);
          pend_rd_nxt_s  = rd_id;
          pend_int_nxt_s = dest_is_int(funct7_id);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (count_r == 5'd0) begin
          state_nxt_s = IDLE;
        end else begin
          count_nxt_s = count_r - 5'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        count_nxt_s = 5'd0;
      end
    endcase
    done_nxt_s = (state_nxt_s == RUN) && (count_nxt_s == 5'd0);
  end

  // State, pending-op bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      count_r     <= 5'd0;
      pend_rd_r   <= 5'd0;
      pend_int_r  <= 1'b0;
      fpu_start_r <= 1'b0;
      fpu_busy_r  <= 1'b0;
      fpu_done_r  <= 1'b0;
      wb_rd_r     <= 5'd0;
      wb_to_int_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      count_r     <= count_nxt_s;
      pend_rd_r   <= pend_rd_nxt_s;
      pend_int_r  <= pend_int_nxt_s;
      fpu_start_r <= issue_s;
      fpu_busy_r  <= (state_nxt_s == RUN);
      fpu_done_r  <= done_nxt_s;
      wb_rd_r     <= done_nxt_s ? pend_rd_nxt_s : 5'd0;
      wb_to_int_r <= done_nxt_s && pend_int_nxt_s;
    end
  end

  assign fpu_start = fpu_start_r;
  assign fpu_busy  = fpu_busy_r;
  assign fpu_done  = fpu_done_r;
  assign wb_rd     = wb_rd_r;
  assign wb_to_int = wb_to_int_r;

endmodule
